input_event_arbiter: RTL and testbench
======================================

# input_event_arbiter

Merges the two keyboard input sources, PS/2 scancodes and USB HID reports, into one tagged byte stream. The stream is buffered in a FIFO that the SoC keyboard peripheral drains. The block sits between the `ps2kbd` / HID-host outputs and the SoC bus, in the `clk` domain. Both sources must already be synchronized into that domain: single-cycle strobes, stable data.

## Interface
- `USB_REPORT_NB_BYTES`, 8: bytes per HID report, 1..15.
- `FIFO_DEPTH`, 32: FIFO entries, power of two, ≥ `USB_REPORT_NB_BYTES`+1.
- `clk` input 1: system clock.
- `reset_n_i` input 1: reset, asynchronous, active-low.
- `ps2_code_i` input 8: PS/2 scancode.
- `ps2_strobe_i` input 1: one-cycle pulse, `ps2_code_i` valid.
- `ps2_err_i` input 1: one-cycle pulse, PS/2 frame error.
- `usb_report_i` input 8·`USB_REPORT_NB_BYTES`: HID report, byte 0 in bits [7:0].
- `usb_report_valid_i` input 1: one-cycle pulse, report valid.
- `rd_i` input 1: pop FIFO head. Ignored when `valid_o`=0.
- `data_o` output 10: FIFO head, as {tag[1:0], byte[7:0]}.
- `valid_o` output 1: FIFO not empty.
- `level_o` output $clog2(`FIFO_DEPTH`)+1: FIFO occupancy.
- `overflow_o` output 1: sticky, set when any event is dropped.
- `clr_overflow_i` input 1: clears `overflow_o`.
- `busy_o` output 1: serializer not IDLE.

## Operation
- Tags:
  - 00: PS/2 code.
  - 01: PS/2 error, byte 0x00.
  - 10: first USB byte.
  - 11: subsequent USB byte.
- PS/2 hold register: one entry (code or error) with a full flag.
  - A strobe or error loads it.
  - If the hold is full and not being consumed this cycle, the new event is dropped and `overflow_o` is set.
  - Strobe and error in the same cycle: the error wins.
- USB hold register: one report with a full flag.
  - A valid pulse loads it.
  - If the hold is full and not being consumed, the new report overwrites it (newest state wins) and `overflow_o` is set.
- Serializer FSM:
  - IDLE:
    - Candidates are the PS/2 hold if full, and the USB hold if full and FIFO free space ≥ `USB_REPORT_NB_BYTES`.
    - Round-robin by `last_src`: the source not served last wins when both are candidates. `last_src` resets to USB, so PS/2 wins the first tie.
    - PS/2 chosen: push one entry, clear the PS/2 hold, stay in IDLE.
    - USB chosen: copy the hold to the shift register, clear the USB hold, push byte 0 (tag 10), go to USB_BYTES.
  - USB_BYTES: push the next byte (tag 11) every cycle. After byte `USB_REPORT_NB_BYTES`-1, return to IDLE.
- A PS/2 push needs ≥1 free entry; otherwise it waits in the hold.
- The space check ignores a same-cycle pop (conservative).
- A report is never split by PS/2 entries and never partially pushed.
- A new report may load the USB hold while USB_BYTES is active.
- `clr_overflow_i` and a drop in the same cycle: `overflow_o` stays 1.

## Timing
- Reset values:
  - `valid_o`=0, `data_o`=0, `level_o`=0, `overflow_o`=0, `busy_o`=0.
  - Holds empty, FSM in IDLE.
- Async assert clears all state, including a half-serialized report. Deassert is synchronized internally to two flops.
- PS/2 latency: strobe sampled at edge E0, hold loads at E0, FIFO push at E1. `valid_o`=1 after E1 if the FIFO was empty.
- USB latency: valid at E0, byte 0 pushed at E1, last byte pushed at E`USB_REPORT_NB_BYTES`.
- FIFO is first-word fall-through. `data_o` shows the head while `valid_o`=1 and is 0 when empty.
- Push and pop in the same cycle: `level_o` unchanged.

## Configuration
- `USB_DEDUP_EN` defined:
  - A valid report equal to the last report accepted into the USB hold is discarded silently (no overflow).
  - The compare register resets to all-zero, so the first all-zero report is discarded.
- `USB_DEDUP_EN` undefined: every report is queued.

## Structure
- Package `input_event_pkg`:
  - Tag enum `event_tag_t`.
  - FSM state enum `arb_state_t` (IDLE, USB_BYTES).
  - Width constant `EVENT_W`=10.
- Sub-module `event_fifo`: synchronous FIFO, parameterized by width and depth, with first-word fall-through, level output and full/empty flags.

## Test plan
- PS/2 strobe with 0x1C → after 2 edges `valid_o`=1, `data_o`=0x01C; `rd_i` → `valid_o`=0.
- USB report 0x0000_0000_0004_0002 → 8 entries: 0x202, 0x300, 0x304, then five 0x300.
- PS/2 strobe 0x5A on the same cycle as a USB report → 0x05A first, then the 8 report entries contiguous.
- FIFO at 30/32 entries, USB report arrives → no push, `busy_o`=0; pop 6 → report pushed intact.
- Two PS/2 strobes 1 cycle apart with the FIFO full → first held, second dropped, `overflow_o`=1; `clr_overflow_i` → 0.
- `USB_DEDUP_EN`: the same non-zero report twice → 8 entries only. Async reset mid-USB_BYTES → all outputs 0 immediately.

Source files
------------

// File: rtl/input_event_pkg.sv
// Shared types and constants for the keyboard input event arbiter.
// Optional feature macro: USB_DEDUP_EN (drop repeated identical HID reports).
package input_event_pkg;

    localparam int EVENT_W = 10;

    // Tag carried in bits [9:8] of every FIFO entry.
    typedef enum logic [1:0] {
        TAG_PS2_CODE  = 2'b00,
        TAG_PS2_ERR   = 2'b01,
        TAG_USB_FIRST = 2'b10,
        TAG_USB_NEXT  = 2'b11
    } event_tag_t;

    // Serializer states.
    typedef enum logic {
        IDLE      = 1'b0,
        USB_BYTES = 1'b1
    } arb_state_t;

    // Source served most recently, used for round-robin.
    typedef enum logic {
        SRC_PS2 = 1'b0,
        SRC_USB = 1'b1
    } src_t;

    function automatic logic [EVENT_W-1:0] make_event(input event_tag_t tag, input logic [7:0] data);
        return {tag, data};
    endfunction

endpackage

// File: rtl/input_event_arbiter_fifo.sv
// event_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Writes when full and reads when empty are ignored.
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_en, rd_en;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign wr_en     = wr_i & ~full_o;
    assign rd_en     = rd_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Pointer and occupancy update; simultaneous push and pop leave the level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        level_d  = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only observed when the level says they are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/input_event_arbiter.sv
// input_event_arbiter: merges PS/2 scancodes and USB HID reports into one
// tagged byte stream buffered in a FWFT FIFO.
// Optional feature macro: USB_DEDUP_EN (discard a report identical to the
// last one accepted into the USB hold register).
//
// Handshake: the PS/2 and USB inputs are single-cycle strobes with no
// backpressure (events that cannot be held are dropped/overwritten and flagged
// on overflow_o); on the read side valid_o=1 means data_o holds the FIFO head,
// and the entry is consumed on a clock edge where rd_i=1 and valid_o=1.
module input_event_arbiter
    import input_event_pkg::*;
#(
    parameter int USB_REPORT_NB_BYTES = 8,
    parameter int FIFO_DEPTH          = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n_i,
    input  logic [7:0]                           ps2_code_i,
    input  logic                                 ps2_strobe_i,
    input  logic                                 ps2_err_i,
    input  logic [8*USB_REPORT_NB_BYTES-1:0]     usb_report_i,
    input  logic                                 usb_report_valid_i,
    input  logic                                 rd_i,
    output logic [EVENT_W-1:0]                   data_o,
    output logic                                 valid_o,
    output logic [$clog2(FIFO_DEPTH):0]          level_o,
    output logic                                 overflow_o,
    input  logic                                 clr_overflow_i,
    output logic                                 busy_o
);

    localparam int RW = 8 * USB_REPORT_NB_BYTES;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    // Highest occupancy at which a whole report still fits.
    localparam logic [LW-1:0] USB_MAX_LEVEL = LW'(FIFO_DEPTH - USB_REPORT_NB_BYTES);
    localparam logic [3:0]    LAST_CNT      = 4'(USB_REPORT_NB_BYTES - 1);

    logic [1:0]         rst_sync_q, rst_sync_d;
    logic               rst_n;

    arb_state_t         state_q, state_d;
    src_t               last_src_q, last_src_d;
    logic [RW-1:0]      shift_q, shift_d;
    logic [3:0]         cnt_q, cnt_d;

    logic               ps2_full_q, ps2_full_d;
    logic [EVENT_W-1:0] ps2_ent_q, ps2_ent_d;
    logic               usb_full_q, usb_full_d;
    logic [RW-1:0]      usb_hold_q, usb_hold_d;
    logic               ovf_q, ovf_d;
    logic               usb_accept;
`ifdef USB_DEDUP_EN
    logic [RW-1:0]      dedup_q, dedup_d;
`endif

    logic               ps2_take, usb_take;
    logic               ps2_cand, usb_cand;
    logic               ps2_drop, usb_drop;
    logic               push;
    logic [EVENT_W-1:0] push_data;
    logic [EVENT_W-1:0] fifo_head;
    logic [LW-1:0]      fifo_level;
    logic               fifo_full, fifo_empty;

    // Reset release is delayed through two flops; assertion is immediate.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer registers.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    // Serializer: round-robin pick in IDLE, then stream the rest of a report.
    always_comb begin
        state_d    = state_q;
        last_src_d = last_src_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        push_data  = '0;
        ps2_take   = 1'b0;
        usb_take   = 1'b0;
        ps2_cand   = ps2_full_q & ~fifo_full;
        usb_cand   = usb_full_q & (fifo_level <= USB_MAX_LEVEL);
        case (state_q)
            IDLE: begin
                if (ps2_cand && (!usb_cand || last_src_q == SRC_USB)) begin
                    push       = 1'b1;
                    push_data  = ps2_ent_q;
                    ps2_take   = 1'b1;
                    last_src_d = SRC_PS2;
                end else if (usb_cand) begin
                    push       = 1'b1;
                    push_data  = make_event(TAG_USB_FIRST, usb_hold_q[7:0]);
                    usb_take   = 1'b1;
                    last_src_d = SRC_USB;
                    shift_d    = usb_hold_q >> 8;
                    cnt_d      = 4'd1;
                    if (USB_REPORT_NB_BYTES > 1) begin
                        state_d = USB_BYTES;
                    end
                end
            end
            USB_BYTES: begin
                push      = 1'b1;
                push_data = make_event(TAG_USB_NEXT, shift_q[7:0]);
                shift_d   = shift_q >> 8;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold registers and sticky overflow: PS/2 drops when blocked, USB overwrites.
    always_comb begin
        ps2_full_d = ps2_full_q & ~ps2_take;
        ps2_ent_d  = ps2_ent_q;
        usb_full_d = usb_full_q & ~usb_take;
        usb_hold_d = usb_hold_q;
        ps2_drop   = 1'b0;
        usb_drop   = 1'b0;
`ifdef USB_DEDUP_EN
        dedup_d    = dedup_q;
        usb_accept = usb_report_valid_i & (usb_report_i != dedup_q);
`else
        usb_accept = usb_report_valid_i;
`endif
        if (ps2_strobe_i || ps2_err_i) begin
            if (!ps2_full_q || ps2_take) begin
                ps2_full_d = 1'b1;
                ps2_ent_d  = ps2_err_i ? make_event(TAG_PS2_ERR, 8'h00)
                                       : make_event(TAG_PS2_CODE, ps2_code_i);
            end else begin
                ps2_drop = 1'b1;
            end
        end
        if (usb_accept) begin
            usb_drop   = usb_full_q & ~usb_take;
            usb_full_d = 1'b1;
            usb_hold_d = usb_report_i;
`ifdef USB_DEDUP_EN
            dedup_d    = usb_report_i;
`endif
        end
        ovf_d = (ovf_q & ~clr_overflow_i) | ps2_drop | usb_drop;
    end

    // State, hold and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_src_q <= SRC_USB;
            shift_q    <= '0;
            cnt_q      <= '0;
            ps2_full_q <= 1'b0;
            ps2_ent_q  <= '0;
            usb_full_q <= 1'b0;
            usb_hold_q <= '0;
            ovf_q      <= 1'b0;
`ifdef USB_DEDUP_EN
            dedup_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ps2_full_q <= ps2_full_d;
            ps2_ent_q  <= ps2_ent_d;
            usb_full_q <= usb_full_d;
            usb_hold_q <= usb_hold_d;
            ovf_q      <= ovf_d;
`ifdef USB_DEDUP_EN
            dedup_q    <= dedup_d;
`endif
        end
    end

    event_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (push),
        .wr_data_i (push_data),
        .rd_i      (rd_i),
        .rd_data_o (fifo_head),
        .level_o   (fifo_level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign valid_o    = ~fifo_empty;
    assign data_o     = fifo_empty ? '0 : fifo_head;
    assign level_o    = fifo_level;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q == USB_BYTES);

endmodule

// File: tb/tb_input_event_arbiter.sv
// Self-checking bench for input_event_arbiter: directed scenarios plus
// randomized traffic, all compared against an event-level reference model.
module tb_input_event_arbiter;

    localparam int NB    = 8;
    localparam int DEPTH = 32;

    logic            clk = 1'b0;
    logic            reset_n_i;
    logic [7:0]      ps2_code_i;
    logic            ps2_strobe_i;
    logic            ps2_err_i;
    logic [8*NB-1:0] usb_report_i;
    logic            usb_report_valid_i;
    logic            rd_i;
    logic            clr_overflow_i;
    logic [9:0]      data_o;
    logic            valid_o;
    logic [5:0]      level_o;
    logic            overflow_o;
    logic            busy_o;

    always #5 clk = ~clk;

    input_event_arbiter #(
        .USB_REPORT_NB_BYTES (NB),
        .FIFO_DEPTH          (DEPTH)
    ) dut (
        .clk                (clk),
        .reset_n_i          (reset_n_i),
        .ps2_code_i         (ps2_code_i),
        .ps2_strobe_i       (ps2_strobe_i),
        .ps2_err_i          (ps2_err_i),
        .usb_report_i       (usb_report_i),
        .usb_report_valid_i (usb_report_valid_i),
        .rd_i               (rd_i),
        .data_o             (data_o),
        .valid_o            (valid_o),
        .level_o            (level_o),
        .overflow_o         (overflow_o),
        .clr_overflow_i     (clr_overflow_i),
        .busy_o             (busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    logic [9:0]      exp_q[$];    // expected FIFO contents, head first
    logic [9:0]      burst_q[$];  // report entries still to be streamed
    bit              m_ps2_full;
    logic [9:0]      m_ps2_ent;
    bit              m_usb_full;
    logic [8*NB-1:0] m_usb_rep;
    bit              m_last_usb;
    bit              m_ovf;
    logic [8*NB-1:0] m_dedup;

    task automatic model_reset();
        exp_q.delete();
        burst_q.delete();
        m_ps2_full = 0;
        m_ps2_ent  = '0;
        m_usb_full = 0;
        m_usb_rep  = '0;
        m_last_usb = 1;
        m_ovf      = 0;
        m_dedup    = '0;
    endtask

    // One clock edge worth of behaviour, using the inputs as sampled at that edge.
    task automatic model_edge();
        int  sz;
        bit  pc, uc, ps2_take, usb_take, pop, accept, drop;
        sz       = exp_q.size();
        pop      = rd_i && (sz > 0);
        ps2_take = 0;
        usb_take = 0;
        drop     = 0;
        if (burst_q.size() > 0) begin
            exp_q.push_back(burst_q.pop_front());
        end else begin
            pc = m_ps2_full && (sz < DEPTH);
            uc = m_usb_full && ((DEPTH - sz) >= NB);
            if (pc && (!uc || m_last_usb)) begin
                exp_q.push_back(m_ps2_ent);
                ps2_take   = 1;
                m_last_usb = 0;
            end else if (uc) begin
                for (int k = 0; k < NB; k++) begin
                    if (k == 0) exp_q.push_back({2'b10, m_usb_rep[8*k +: 8]});
                    else        burst_q.push_back({2'b11, m_usb_rep[8*k +: 8]});
                end
                usb_take   = 1;
                m_last_usb = 1;
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (ps2_strobe_i || ps2_err_i) begin
            if (!m_ps2_full || ps2_take) begin
                m_ps2_full = 1;
                m_ps2_ent  = ps2_err_i ? 10'h100 : {2'b00, ps2_code_i};
            end else begin
                drop = 1;
            end
        end else if (ps2_take) begin
            m_ps2_full = 0;
        end
`ifdef USB_DEDUP_EN
        accept = usb_report_valid_i && (usb_report_i != m_dedup);
`else
        accept = usb_report_valid_i;
`endif
        if (accept) begin
            if (m_usb_full && !usb_take) drop = 1;
            m_usb_full = 1;
            m_usb_rep  = usb_report_i;
            m_dedup    = usb_report_i;
        end else if (usb_take) begin
            m_usb_full = 0;
        end
        m_ovf = (m_ovf && !clr_overflow_i) || drop;
    endtask

    task automatic check_outputs();
        check("valid",    valid_o,    exp_q.size() > 0);
        check("data",     data_o,     exp_q.size() > 0 ? exp_q[0] : 10'h000);
        check("level",    level_o,    exp_q.size());
        check("overflow", overflow_o, m_ovf);
        check("busy",     busy_o,     burst_q.size() > 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        if (reset_n_i) model_edge();
        #1;
        check_outputs();
        ps2_strobe_i       = 0;
        ps2_err_i          = 0;
        usb_report_valid_i = 0;
        clr_overflow_i     = 0;
        rd_i               = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ps2(input logic [7:0] c);
        ps2_code_i   = c;
        ps2_strobe_i = 1;
        tick();
    endtask

    task automatic usb(input logic [8*NB-1:0] r);
        usb_report_i       = r;
        usb_report_valid_i = 1;
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [9:0] e);
        check(tag, data_o, e);
        rd_i = 1;
        tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            rd_i = 1;
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    logic [9:0] e2 [8];
    logic [9:0] e3 [8];

    initial begin
        e2 = '{10'h202, 10'h300, 10'h304, 10'h300, 10'h300, 10'h300, 10'h300, 10'h300};
        e3 = '{10'h288, 10'h377, 10'h366, 10'h355, 10'h344, 10'h333, 10'h322, 10'h311};
        reset_n_i          = 0;
        ps2_code_i         = '0;
        ps2_strobe_i       = 0;
        ps2_err_i          = 0;
        usb_report_i       = '0;
        usb_report_valid_i = 0;
        rd_i               = 0;
        clr_overflow_i     = 0;
        model_reset();

        #12;
        check("rst_valid",    valid_o,    1'b0);
        check("rst_data",     data_o,     10'h000);
        check("rst_level",    level_o,    6'd0);
        check("rst_overflow", overflow_o, 1'b0);
        check("rst_busy",     busy_o,     1'b0);
        @(negedge clk);
        reset_n_i = 1;
        idle(4);

        // single PS/2 scancode: visible two edges after the strobe
        ps2(8'h1C);
        check("t1_not_yet", valid_o, 1'b0);
        idle(1);
        check("t1_valid", valid_o, 1'b1);
        check("t1_data",  data_o,  10'h01C);
        pop_expect("t1_pop", 10'h01C);
        check("t1_empty", valid_o, 1'b0);

        // one USB report serialized into eight tagged bytes
        usb(64'h0000_0000_0004_0002);
        idle(8);
        check("t2_level", level_o, 6'd8);
        for (int i = 0; i < 8; i++) pop_expect("t2_byte", e2[i]);

        // PS/2 and USB together: PS/2 first, report contiguous after it
        ps2_code_i         = 8'h5A;
        ps2_strobe_i       = 1;
        usb_report_i       = 64'h1122_3344_5566_7788;
        usb_report_valid_i = 1;
        tick();
        idle(9);
        check("t3_level", level_o, 6'd9);
        pop_expect("t3_ps2", 10'h05A);
        for (int i = 0; i < 8; i++) pop_expect("t3_byte", e3[i]);

        // report waits for room when the FIFO is nearly full
        for (int i = 0; i < 30; i++) ps2(8'(i));
        idle(1);
        check("t4_level30", level_o, 6'd30);
        usb(64'hDEAD_BEEF_0102_0304);
        idle(3);
        check("t4_busy_wait", busy_o,  1'b0);
        check("t4_no_push",   level_o, 6'd30);
        for (int i = 0; i < 6; i++) pop_expect("t4_pop", 10'(i));
        idle(9);
        check("t4_level32", level_o, 6'd32);

        // FIFO full: first strobe held, second dropped, overflow sticky until cleared
        ps2(8'hA1);
        ps2(8'hA2);
        check("t5_ovf_set", overflow_o, 1'b1);
        clr_overflow_i = 1;
        tick();
        check("t5_ovf_clr", overflow_o, 1'b0);
        drain(40);
        check("t5_drained", level_o, 6'd0);

        // the same report twice
        usb(64'h0BAD_F00D_CAFE_0042);
        idle(12);
        usb(64'h0BAD_F00D_CAFE_0042);
        idle(12);
`ifdef USB_DEDUP_EN
        check("t6_dedup_level", level_o, 6'd8);
`else
        check("t6_dup_level", level_o, 6'd16);
`endif
        drain(20);

        // asynchronous reset in the middle of a report
        usb(64'h0102_0304_0506_0708);
        tick();
        check("t7_busy", busy_o, 1'b1);
        #2;
        reset_n_i = 0;
        #1;
        check("t7_valid",    valid_o,    1'b0);
        check("t7_data",     data_o,     10'h000);
        check("t7_level",    level_o,    6'd0);
        check("t7_overflow", overflow_o, 1'b0);
        check("t7_busy0",    busy_o,     1'b0);
        model_reset();
        tick();
        reset_n_i = 1;
        idle(4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int rd_pct;
            rd_pct = ((i / 400) % 2 == 1) ? 15 : 75;
            if ($urandom_range(0, 99) < 30) begin
                ps2_code_i   = 8'($urandom);
                ps2_strobe_i = 1;
            end
            if ($urandom_range(0, 99) < 5) ps2_err_i = 1;
            if ($urandom_range(0, 99) < 5) begin
                case ($urandom_range(0, 3))
                    0:       usb_report_i = '0;
                    1:       usb_report_i = 64'h0000_0000_0004_0002;
                    2:       usb_report_i = 64'h1122_3344_5566_7788;
                    default: usb_report_i = {$urandom, $urandom};
                endcase
                usb_report_valid_i = 1;
            end
            if ($urandom_range(0, 99) < rd_pct) rd_i = 1;
            if ($urandom_range(0, 99) < 3) clr_overflow_i = 1;
            tick();
        end
        drain(60);
        check("final_empty", level_o, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
